execute_unit_iterative: RTL

- Parametrised successor to the single-cycle execute unit.
- Accepts decoded RV32E/RV32I integer ops over a valid/ready handshake and performs ALU, compare, branch and jump evaluation.
- Drives a registered register-file write port and a one-cycle PC redirect to the control unit.
- Shifts run on an iterative multi-cycle shifter under a small FSM. Loads, stores and unknown ops raise a one-cycle illegal pulse and write nothing. Sits between the decoder skid buffer and the register file / control unit.

---
 rtl/execute_unit_iterative_if.sv | 83 ++++++++
 rtl/execute_unit_iterative.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_unit_iterative_if.sv
// Shared decoded-op encoding plus the execute unit's handshake / writeback bus.
// Package: execute_unit_iterative_pkg
//   Decoded-instruction enum values INST_LUI .. INST_NOP.
// Interface: execute_unit_iterative_if
//   Parameters: XLEN (datapath width), RA (register address width), OPW (op field width).
//   Carries the issue side (in_*) and the result side (rf_*, set_pc/new_pc,
//   illegal, busy).
//   Modports:
//     master - decoder / testbench side; drives in_*.
//     slave  - execute unit side; drives in_ready and the result outputs.

package execute_unit_iterative_pkg;
    localparam logic [5:0] INST_LUI   = 6'd0;
    localparam logic [5:0] INST_AUIPC = 6'd1;
    localparam logic [5:0] INST_JAL   = 6'd2;
    localparam logic [5:0] INST_JALR  = 6'd3;
    localparam logic [5:0] INST_BEQ   = 6'd4;
    localparam logic [5:0] INST_BNE   = 6'd5;
    localparam logic [5:0] INST_BLT   = 6'd6;
    localparam logic [5:0] INST_BGE   = 6'd7;
    localparam logic [5:0] INST_BLTU  = 6'd8;
    localparam logic [5:0] INST_BGEU  = 6'd9;
    localparam logic [5:0] INST_LB    = 6'd10;
    localparam logic [5:0] INST_LH    = 6'd11;
    localparam logic [5:0] INST_LW    = 6'd12;
    localparam logic [5:0] INST_LBU   = 6'd13;
    localparam logic [5:0] INST_LHU   = 6'd14;
    localparam logic [5:0] INST_SB    = 6'd15;
    localparam logic [5:0] INST_SH    = 6'd16;
    localparam logic [5:0] INST_SW    = 6'd17;
    localparam logic [5:0] INST_ADDI  = 6'd18;
    localparam logic [5:0] INST_SLTI  = 6'd19;
    localparam logic [5:0] INST_SLTIU = 6'd20;
    localparam logic [5:0] INST_XORI  = 6'd21;
    localparam logic [5:0] INST_ORI   = 6'd22;
    localparam logic [5:0] INST_ANDI  = 6'd23;
    localparam logic [5:0] INST_SLLI  = 6'd24;
    localparam logic [5:0] INST_SRLI  = 6'd25;
    localparam logic [5:0] INST_SRAI  = 6'd26;
    localparam logic [5:0] INST_ADD   = 6'd27;
    localparam logic [5:0] INST_SUB   = 6'd28;
    localparam logic [5:0] INST_SLL   = 6'd29;
    localparam logic [5:0] INST_SLT   = 6'd30;
    localparam logic [5:0] INST_SLTU  = 6'd31;
    localparam logic [5:0] INST_XOR   = 6'd32;
    localparam logic [5:0] INST_SRL   = 6'd33;
    localparam logic [5:0] INST_SRA   = 6'd34;
    localparam logic [5:0] INST_OR    = 6'd35;
    localparam logic [5:0] INST_AND   = 6'd36;
    localparam logic [5:0] INST_NOP   = 6'd37;
endpackage

interface execute_unit_iterative_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA   = 4,
    parameter int unsigned OPW  = 6
);
    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  in_op;
    logic [RA-1:0]   in_rd;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_pc;
    logic            rf_we;
    logic [RA-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            set_pc;
    logic [XLEN-1:0] new_pc;
    logic            illegal;
    logic            busy;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_pc,
        input  in_ready, rf_we, rf_waddr, rf_wdata, set_pc, new_pc, illegal, busy
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_pc,
        output in_ready, rf_we, rf_waddr, rf_wdata, set_pc, new_pc, illegal, busy
    );
endinterface

// File: rtl/execute_unit_iterative.sv
// Integer execute unit for decoded RV32E/RV32I ops: ALU, compare, branch and
// jump evaluation with a registered register-file write port and a one-cycle
// PC redirect. Shifts run on an iterative shifter (SHIFT_STEP bits per cycle)
// under a small IDLE/SHIFT/WB FSM. Loads, stores and unknown ops pulse illegal.
// Optional build macro: EXECUTE_BARREL_SHIFT_EN -- shifts use a single-cycle
// barrel shifter, the FSM is not built, in_ready stays 1 and busy stays 0.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset
//   io_bus - execute_unit_iterative_if.slave: in_valid/in_ready handshake with
//            in_op/in_rd/in_rs1/in_rs2/in_imm/in_pc; outputs rf_we/rf_waddr/
//            rf_wdata, set_pc/new_pc, illegal, busy.

module execute_unit_iterative
    import execute_unit_iterative_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned SHIFT_STEP = 1,
    parameter int unsigned OPW        = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    execute_unit_iterative_if.slave io_bus
);

    localparam int unsigned RA  = $clog2(NUM_REGS);
    localparam int unsigned SAW = (XLEN == 64) ? 6 : 5;

    // One shift of v by a bit positions; arithmetic right fills with the sign bit.
    function automatic logic [XLEN-1:0] f_shift(
        input logic [XLEN-1:0] v,
        input logic [SAW-1:0]  a,
        input logic            left,
        input logic            arith
    );
        if (left)
            return v << a;
        else if (arith)
            return XLEN'($signed(v) >>> a);
        else
            return v >> a;
    endfunction

    // Result / strobe registers
    logic            r_rf_we;
    logic [RA-1:0]   r_rf_waddr;
    logic [XLEN-1:0] r_rf_wdata;
    logic            r_set_pc;
    logic [XLEN-1:0] r_new_pc;
    logic            r_illegal;

    // Decode / ALU wires
    logic            w_xfer;
    logic            w_issue;
    logic            w_wr;
    logic [XLEN-1:0] w_wdata;
    logic            w_redir;
    logic [XLEN-1:0] w_target;
    logic            w_illegal;
    logic            w_is_shift;
    logic            w_sh_left;
    logic            w_sh_arith;
    logic [SAW-1:0]  w_sh_amt;
    logic [XLEN-1:0] w_pc_imm;
    logic [XLEN-1:0] w_pc_4;
    logic [XLEN-1:0] w_rs1_imm;
    logic            w_lt_rr_s;
    logic            w_lt_rr_u;
    logic            w_lt_ri_s;
    logic            w_lt_ri_u;
    logic            w_rd_nz;

`ifndef EXECUTE_BARREL_SHIFT_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_sh_val;
    logic [SAW-1:0]  r_sh_rem;
    logic            r_sh_left;
    logic            r_sh_arith;
    logic [RA-1:0]   r_sh_rd;
    logic [SAW-1:0]  w_step;
    logic [XLEN-1:0] w_sh_next;

    assign io_bus.in_ready = (r_state == S_IDLE);
    assign io_bus.busy     = (r_state != S_IDLE);

    // Bits consumed this SHIFT cycle: min(remaining, SHIFT_STEP)
    assign w_step    = (r_sh_rem > SAW'(SHIFT_STEP)) ? SAW'(SHIFT_STEP) : r_sh_rem;
    assign w_sh_next = f_shift(r_sh_val, w_step, r_sh_left, r_sh_arith);
    assign w_issue   = w_xfer & ~w_is_shift;
`else
    assign io_bus.in_ready = 1'b1;
    assign io_bus.busy     = 1'b0;
    assign w_issue         = w_xfer;
`endif

    assign w_xfer    = io_bus.in_valid & io_bus.in_ready;
    assign w_pc_imm  = io_bus.in_pc + io_bus.in_imm;
    assign w_pc_4    = io_bus.in_pc + XLEN'(4);
    assign w_rs1_imm = io_bus.in_rs1 + io_bus.in_imm;
    assign w_lt_rr_s = $signed(io_bus.in_rs1) < $signed(io_bus.in_rs2);
    assign w_lt_rr_u = io_bus.in_rs1 < io_bus.in_rs2;
    assign w_lt_ri_s = $signed(io_bus.in_rs1) < $signed(io_bus.in_imm);
    assign w_lt_ri_u = io_bus.in_rs1 < io_bus.in_imm;
    assign w_rd_nz   = (io_bus.in_rd != '0);

    // Op decode and single-cycle result
    always_comb begin
        w_wr       = 1'b0;
        w_wdata    = '0;
        w_redir    = 1'b0;
        w_target   = w_pc_imm;
        w_illegal  = 1'b0;
        w_is_shift = 1'b0;
        w_sh_left  = 1'b0;
        w_sh_arith = 1'b0;
        w_sh_amt   = io_bus.in_imm[SAW-1:0];
        case (io_bus.in_op)
            OPW'(INST_LUI):   begin w_wr = 1'b1; w_wdata = io_bus.in_imm; end
            OPW'(INST_AUIPC): begin w_wr = 1'b1; w_wdata = w_pc_imm; end
            OPW'(INST_JAL):   begin w_wr = 1'b1; w_wdata = w_pc_4; w_redir = 1'b1; end
            OPW'(INST_JALR): begin
                w_wr     = 1'b1;
                w_wdata  = w_pc_4;
                w_redir  = 1'b1;
                w_target = {w_rs1_imm[XLEN-1:1], 1'b0};
            end
            OPW'(INST_BEQ):   w_redir = (io_bus.in_rs1 == io_bus.in_rs2);
            OPW'(INST_BNE):   w_redir = (io_bus.in_rs1 != io_bus.in_rs2);
            OPW'(INST_BLT):   w_redir = w_lt_rr_s;
            OPW'(INST_BGE):   w_redir = ~w_lt_rr_s;
            OPW'(INST_BLTU):  w_redir = w_lt_rr_u;
            OPW'(INST_BGEU):  w_redir = ~w_lt_rr_u;
            OPW'(INST_ADDI):  begin w_wr = 1'b1; w_wdata = w_rs1_imm; end
            OPW'(INST_SLTI):  begin w_wr = 1'b1; w_wdata = XLEN'(w_lt_ri_s); end
            OPW'(INST_SLTIU): begin w_wr = 1'b1; w_wdata = XLEN'(w_lt_ri_u); end
            OPW'(INST_XORI):  begin w_wr = 1'b1; w_wdata = io_bus.in_rs1 ^ io_bus.in_imm; end
            OPW'(INST_ORI):   begin w_wr = 1'b1; w_wdata = io_bus.in_rs1 | io_bus.in_imm; end
            OPW'(INST_ANDI):  begin w_wr = 1'b1; w_wdata = io_bus.in_rs1 & io_bus.in_imm; end
            OPW'(INST_SLLI):  begin w_is_shift = 1'b1; w_sh_left = 1'b1; end
            OPW'(INST_SRLI):  w_is_shift = 1'b1;
            OPW'(INST_SRAI):  begin w_is_shift = 1'b1; w_sh_arith = 1'b1; end
            OPW'(INST_ADD):   begin w_wr = 1'b1; w_wdata = io_bus.in_rs1 + io_bus.in_rs2; end
            OPW'(INST_SUB):   begin w_wr = 1'b1; w_wdata = io_bus.in_rs1 - io_bus.in_rs2; end
            OPW'(INST_SLL): begin
                w_is_shift = 1'b1;
                w_sh_left  = 1'b1;
                w_sh_amt   = io_bus.in_rs2[SAW-1:0];
            end
            OPW'(INST_SLT):   begin w_wr = 1'b1; w_wdata = XLEN'(w_lt_rr_s); end
            OPW'(INST_SLTU):  begin w_wr = 1'b1; w_wdata = XLEN'(w_lt_rr_u); end
            OPW'(INST_XOR):   begin w_wr = 1'b1; w_wdata = io_bus.in_rs1 ^ io_bus.in_rs2; end
            OPW'(INST_SRL): begin
                w_is_shift = 1'b1;
                w_sh_amt   = io_bus.in_rs2[SAW-1:0];
            end
            OPW'(INST_SRA): begin
                w_is_shift = 1'b1;
                w_sh_arith = 1'b1;
                w_sh_amt   = io_bus.in_rs2[SAW-1:0];
            end
            OPW'(INST_OR):    begin w_wr = 1'b1; w_wdata = io_bus.in_rs1 | io_bus.in_rs2; end
            OPW'(INST_AND):   begin w_wr = 1'b1; w_wdata = io_bus.in_rs1 & io_bus.in_rs2; end
            OPW'(INST_NOP):   ;
            default:          w_illegal = 1'b1;
        endcase
`ifdef EXECUTE_BARREL_SHIFT_EN
        if (w_is_shift) begin
            w_wr    = 1'b1;
            w_wdata = f_shift(io_bus.in_rs1, w_sh_amt, w_sh_left, w_sh_arith);
        end
`endif
    end

    // Strobes, held result registers and the shift FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_set_pc   <= 1'b0;
            r_new_pc   <= '0;
            r_illegal  <= 1'b0;
`ifndef EXECUTE_BARREL_SHIFT_EN
            r_state    <= S_IDLE;
            r_sh_val   <= '0;
            r_sh_rem   <= '0;
            r_sh_left  <= 1'b0;
            r_sh_arith <= 1'b0;
            r_sh_rd    <= '0;
`endif
        end else begin
            r_rf_we   <= 1'b0;
            r_set_pc  <= 1'b0;
            r_illegal <= 1'b0;

            // Single-cycle ops: address/data/target only move with their strobe
            if (w_issue) begin
                if (w_wr && w_rd_nz) begin
                    r_rf_we    <= 1'b1;
                    r_rf_waddr <= io_bus.in_rd;
                    r_rf_wdata <= w_wdata;
                end
                if (w_redir) begin
                    r_set_pc <= 1'b1;
                    r_new_pc <= w_target;
                end
                r_illegal <= w_illegal;
            end

`ifndef EXECUTE_BARREL_SHIFT_EN
            case (r_state)
                S_IDLE: begin
                    if (w_xfer && w_is_shift) begin
                        r_sh_val   <= io_bus.in_rs1;
                        r_sh_rem   <= w_sh_amt;
                        r_sh_left  <= w_sh_left;
                        r_sh_arith <= w_sh_arith;
                        r_sh_rd    <= io_bus.in_rd;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sh_val <= w_sh_next;
                    r_sh_rem <= r_sh_rem - w_step;
                    // Last step (also taken immediately for amt=0): write lands in WB
                    if (r_sh_rem == w_step) begin
                        r_state <= S_WB;
                        if (r_sh_rd != '0) begin
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= r_sh_rd;
                            r_rf_wdata <= w_sh_next;
                        end
                    end
                end
                S_WB:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
`endif
        end
    end

    assign io_bus.rf_we    = r_rf_we;
    assign io_bus.rf_waddr = r_rf_waddr;
    assign io_bus.rf_wdata = r_rf_wdata;
    assign io_bus.set_pc   = r_set_pc;
    assign io_bus.new_pc   = r_new_pc;
    assign io_bus.illegal  = r_illegal;

endmodule
